// File: rtl/reset_btn_conditioner.sv
// rtl/reset_btn_conditioner.sv - system reset sequencing plus push-button sync/debounce
// rst_out leaves reset only after `locked` has been stable; buttons yield levels and edge pulses.
module reset_btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DB_CYCLES       = 650000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic [N_BTN-1:0] btn_in,
  output logic             rst_out,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  logic [1:0]             rsync_q;
  logic                   rst_int;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [N_BTN-1:0]       btn_sync_q [SYNC_STAGES];
  logic                   locked_s;
  logic [N_BTN-1:0]       btn_s;

  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   rst_out_q, rst_out_d;

  logic [CW-1:0]          db_cnt_q [N_BTN];
  logic [CW-1:0]          db_cnt_d [N_BTN];
  logic [N_BTN-1:0]       level_q, level_d;
  logic [N_BTN-1:0]       prev_q, press_q, release_q;
  logic                   report_en;

  // Internal reset asserts with rst and releases on the second clock after it falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsync_q <= 2'b11;
    else     rsync_q <= {rsync_q[0], 1'b0};
  end
  assign rst_int = rsync_q[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      lock_sync_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) btn_sync_q[k] <= '0;
    end else begin
      lock_sync_q   <= {lock_sync_q[SYNC_STAGES-2:0], locked};
      btn_sync_q[0] <= btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) btn_sync_q[k] <= btn_sync_q[k-1];
    end
  end
  assign locked_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s    = btn_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      WAIT_LOCK: if (locked_s) begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
      HOLD: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(RST_HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN:     if (!locked_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
    rst_out_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      rst_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_out_q  <= rst_out_d;
    end
  end

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s[i] != level_q[i]) begin
        if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) level_d[i] = ~level_q[i];
        else                                   db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Pulses are suppressed on both sides of any reset boundary so edges seen in reset never leak out.
  assign report_en = ~rst_out_q & ~rst_out_d;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
      level_q   <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      level_q   <= level_d;
      prev_q    <= level_q;
      press_q   <= (level_q & ~prev_q) & {N_BTN{report_en}};
      release_q <= (~level_q & prev_q) & {N_BTN{report_en}};
    end
  end

  assign rst_out     = rst_out_q;
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_reset_btn_conditioner.sv
// tb/tb_reset_btn_conditioner.sv - randomized and directed bench against a timing-rule reference model
module tb_reset_btn_conditioner;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int H  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         locked = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic         rst_out;
  logic [N-1:0] btn_level, btn_press, btn_release;

  always #5 clk = ~clk;

  reset_btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(2), .DB_CYCLES(DB), .RST_HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .btn_in(btn_in),
    .rst_out(rst_out), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges counted since rst fell, inputs seen two edges late,
  // reset released after H+1 consecutive high lock samples, level flips after DB differing samples.
  int           m_edges = 0;
  int           lk_run = 0;
  int           diff_run [N];
  logic         lk_q [$];
  logic [N-1:0] bt_q [$];
  logic         u_lk;
  logic [N-1:0] u_bt;
  logic         m_rso = 1'b1, new_rso;
  logic [N-1:0] m_lvl = '0, m_lvl_prev = '0, new_lvl;
  logic [N-1:0] m_press = '0, m_rel = '0;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_edges = 0; lk_run = 0;
      for (int i = 0; i < N; i++) diff_run[i] = 0;
      lk_q.delete(); bt_q.delete();
      m_rso = 1'b1; m_lvl = '0; m_lvl_prev = '0; m_press = '0; m_rel = '0;
    end else begin
      m_edges++;
      if (m_edges >= 3) begin
        lk_q.push_back(locked); bt_q.push_back(btn_in);
        if (lk_q.size() > 3) begin void'(lk_q.pop_front()); void'(bt_q.pop_front()); end
        u_lk = (lk_q.size() == 3) ? lk_q[0] : 1'b0;
        u_bt = (bt_q.size() == 3) ? bt_q[0] : '0;
        lk_run  = u_lk ? lk_run + 1 : 0;
        new_rso = !(lk_run >= H + 1);
        new_lvl = m_lvl;
        for (int i = 0; i < N; i++) begin
          diff_run[i] = (u_bt[i] != m_lvl[i]) ? diff_run[i] + 1 : 0;
          if (diff_run[i] == DB) begin new_lvl[i] = ~m_lvl[i]; diff_run[i] = 0; end
        end
        m_press    = (m_lvl & ~m_lvl_prev) & {N{~m_rso & ~new_rso}};
        m_rel      = (~m_lvl & m_lvl_prev) & {N{~m_rso & ~new_rso}};
        m_lvl_prev = m_lvl;
        m_lvl      = new_lvl;
        m_rso      = new_rso;
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    chk("rst_out", 32'(rst_out), 32'(m_rso));
    chk("btn_level", 32'(btn_level), 32'(m_lvl));
    chk("btn_press", 32'(btn_press), 32'(m_press));
    chk("btn_release", 32'(btn_release), 32'(m_rel));
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic edges_until_rst_out(input logic val, output int e);
    e = 0;
    do begin tick(); e++; end while (rst_out !== val && e < 60);
  endtask

  int e, np, nr, nother;
  int hold_left [N];
  int lock_left, rst_left;

  initial begin
    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    edges_until_rst_out(1'b0, e);
    chk("powerup_release_edge", 32'(e), 32'd9);

    rst = 1'b1; locked = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("late_lock_still_reset", 32'(rst_out), 32'd1);
    locked = 1'b1;
    edges_until_rst_out(1'b0, e);
    chk("late_lock_release_edge", 32'(e), 32'd7);

    locked = 1'b0;
    edges_until_rst_out(1'b1, e);
    chk("lock_loss_edge", 32'(e), 32'd3);
    locked = 1'b1;
    repeat (4) tick();
    locked = 1'b0; tick(); locked = 1'b1;
    edges_until_rst_out(1'b0, e);
    chk("hold_restart_edge", 32'(e), 32'd7);

    btn_in = 4'b0100;
    np = 0; nother = 0; e = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (btn_level[2] && e == 0) e = t;
      if (btn_press == 4'b0100) np++;
      else if (btn_press != 0 || btn_release != 0) nother++;
    end
    chk("press_level_edge", 32'(e), 32'd10);
    chk("press_pulse_count", 32'(np), 32'd1);
    btn_in = 4'b0000;
    nr = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (btn_release == 4'b0100) nr++;
      else if (btn_press != 0 || btn_release != 0) nother++;
    end
    chk("release_pulse_count", 32'(nr), 32'd1);
    chk("stray_pulses", 32'(nother), 32'd0);

    np = 0;
    for (int t = 0; t < 10; t++) begin
      btn_in[0] = ~btn_in[0];
      repeat (3) begin tick(); if (btn_press[0]) np++; end
    end
    btn_in[0] = 1'b1;
    e = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (btn_level[0] && e == 0) e = t;
      if (btn_press[0]) np++;
    end
    chk("bounce_level_edge", 32'(e), 32'd10);
    chk("bounce_press_count", 32'(np), 32'd1);

    btn_in = 4'b0011;
    repeat (5) tick();
    rst = 1'b1; locked = 1'b0;
    #1;
    chk("midrst_rst_out", 32'(rst_out), 32'd1);
    chk("midrst_outputs", 32'({btn_level, btn_press, btn_release}), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (15) tick();
    locked = 1'b1;
    edges_until_rst_out(1'b0, e);
    chk("midrst_level_at_release", 32'(btn_level[1]), 32'd1);
    np = 0;
    repeat (20) begin tick(); if (btn_press[1]) np++; end
    chk("midrst_no_press", 32'(np), 32'd0);

    for (int i = 0; i < N; i++) hold_left[i] = 0;
    lock_left = 0; rst_left = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          btn_in[i]    = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 40);
        end else hold_left[i]--;
      end
      if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) locked = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        locked = 1'b0; lock_left = $urandom_range(1, 30);
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; rst_left = $urandom_range(1, 4);
        #1 chk("rand_async_rst", 32'({rst_out, btn_level, btn_press, btn_release}), 32'h1000);
      end
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
